fft_host_seq: RTL and testbench

Parametrised host-side sequencer and sample buffer for the FFT engine. It owns an N_POINTS × complex sample RAM and accepts the pin-level command protocol (IDLE / LOAD / EXEC / READ), extended with auto-incrementing pointers, a real-only load mode and explicit pointer seeding. This removes the 5-bit address ceiling of the pin protocol for any point count. It sits between the tt_um top-level pin mapping and the FFT core: it hands the buffer to the core for in-place computation and reports busy/done/full status.

---
 rtl/fft_host_seq.sv | 195 +++++++++++++++++++
 tb/tb_fft_host_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_host_seq.sv
// Host-side sequencer and sample buffer for the FFT engine.
// Holds N_POINTS complex samples, runs the IDLE/LOAD/EXEC/READ host protocol
// with an auto-incrementing pointer, and lends the buffer to the core during EXEC.
module fft_host_seq #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [2:0]            cmd,
    input  logic                  sel,
    input  logic                  stb,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  full,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic                  core_we,
    input  logic [2*DATA_W-1:0]   core_wdata,
    output logic [2*DATA_W-1:0]   core_rdata
);

    localparam logic [2:0] CMD_IDLE      = 3'b000;
    localparam logic [2:0] CMD_LOAD      = 3'b001;
    localparam logic [2:0] CMD_EXEC      = 3'b010;
    localparam logic [2:0] CMD_READ      = 3'b011;
    localparam logic [2:0] CMD_LOAD_REAL = 3'b100;
    localparam logic [2:0] CMD_SET_PTR   = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Sample buffer, split per component so a single component can be written.
    logic [DATA_W-1:0] mem_re [N_POINTS];
    logic [DATA_W-1:0] mem_im [N_POINTS];

    state_t              state_q, state_d;
    logic                core_start_q, core_start_d;
    logic                done_q, done_d;
    logic                full_q, full_d;
    logic                exec_prev_q, exec_prev_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;

    logic [2:0]          cmd_eff;
    logic [ADDR_W-1:0]   ptr_seed;
    logic [ADDR_W-1:0]   ptr_inc;
    logic                ptr_last;
    logic                host_we_re;
    logic                host_we_im;
    logic [DATA_W-1:0]   host_wd_im;

    // Pointer seed: take the low address bits, zero-extend when the pointer is wider.
    generate
        if (ADDR_W <= DATA_W) begin : g_seed_trunc
            assign ptr_seed = data_in[ADDR_W-1:0];
        end else begin : g_seed_ext
            assign ptr_seed = {{(ADDR_W-DATA_W){1'b0}}, data_in};
        end
    endgenerate

    assign ptr_inc  = ptr_q + ADDR_W'(1);
    assign ptr_last = (ptr_q == ADDR_W'(N_POINTS - 1));

    // Effective command: disabled block or reserved codes behave as IDLE.
    always_comb begin
        cmd_eff = CMD_IDLE;
        if (ena) begin
            case (cmd)
                CMD_LOAD, CMD_EXEC, CMD_READ,
                CMD_LOAD_REAL, CMD_SET_PTR: cmd_eff = cmd;
                default:                    cmd_eff = CMD_IDLE;
            endcase
        end
    end

    // Next-state logic: EXEC edge detect, host command decode, core completion.
    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        done_d       = done_q;
        full_d       = full_q;
        ptr_d        = ptr_q;
        data_out_d   = data_out_q;
        exec_prev_d  = (cmd_eff == CMD_EXEC);
        host_we_re   = 1'b0;
        host_we_im   = 1'b0;
        host_wd_im   = data_in;

        case (state_q)
            ST_IDLE: begin
                if ((cmd_eff == CMD_EXEC) && !exec_prev_q) begin
                    state_d      = ST_BUSY;
                    core_start_d = 1'b1;
                    done_d       = 1'b0;
                    full_d       = 1'b0;
                    ptr_d        = '0;
                end else begin
                    case (cmd_eff)
                        CMD_LOAD: begin
                            if (stb) begin
                                done_d = 1'b0;
                                if (sel) begin
                                    host_we_im = 1'b1;
                                    ptr_d      = ptr_inc;
                                    if (ptr_last) full_d = 1'b1;
                                end else begin
                                    host_we_re = 1'b1;
                                end
                            end
                        end
                        CMD_LOAD_REAL: begin
                            if (stb) begin
                                done_d     = 1'b0;
                                host_we_re = 1'b1;
                                host_we_im = 1'b1;
                                host_wd_im = '0;
                                ptr_d      = ptr_inc;
                                if (ptr_last) full_d = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            data_out_d = sel ? mem_im[ptr_q] : mem_re[ptr_q];
                            // A read wrap advances the pointer but never sets full.
                            if (stb && sel) ptr_d = ptr_inc;
                        end
                        CMD_SET_PTR: begin
                            if (stb) begin
                                ptr_d  = ptr_seed;
                                full_d = 1'b0;
                                done_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // The start cycle's core_done is ignored so a run lasts at least two cycles.
                if (core_done && !core_start_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            done_q       <= 1'b0;
            full_q       <= 1'b0;
            exec_prev_q  <= 1'b0;
            ptr_q        <= '0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            done_q       <= done_d;
            full_q       <= full_d;
            exec_prev_q  <= exec_prev_d;
            ptr_q        <= ptr_d;
            data_out_q   <= data_out_d;
        end
    end

    // Buffer writes: the core owns the buffer while busy, the host otherwise; contents are not reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_BUSY) && core_we) begin
            mem_re[core_addr] <= core_wdata[DATA_W-1:0];
            mem_im[core_addr] <= core_wdata[2*DATA_W-1:DATA_W];
        end else begin
            if (host_we_re) mem_re[ptr_q] <= data_in;
            if (host_we_im) mem_im[ptr_q] <= host_wd_im;
        end
    end

    assign core_rdata = {mem_im[core_addr], mem_re[core_addr]};
    assign data_out   = data_out_q;
    assign busy       = (state_q == ST_BUSY);
    assign done       = done_q;
    assign full       = full_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_fft_host_seq.sv
// Directed bench for fft_host_seq: load, read, EXEC handshake, wrap and reset cases.
module tb_fft_host_seq;

    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_LOAD  = 3'b001;
    localparam logic [2:0] C_EXEC  = 3'b010;
    localparam logic [2:0] C_READ  = 3'b011;
    localparam logic [2:0] C_LREAL = 3'b100;
    localparam logic [2:0] C_SETP  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [2:0]  cmd = C_IDLE;
    logic        sel = 1'b0;
    logic        stb = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        busy, done, full, core_start;
    logic        core_done = 1'b0;
    logic [5:0]  core_addr = 6'd0;
    logic        core_we = 1'b0;
    logic [15:0] core_wdata = 16'h0000;
    logic [15:0] core_rdata;

    int checks = 0;
    int errors = 0;
    int starts;

    byte sine_tab [16] = '{0, 19, 38, 50, 50, 50, 38, 19, 0, -19, -38, -50, -50, -50, -38, -19};

    fft_host_seq #(.N_POINTS(64), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .cmd        (cmd),
        .sel        (sel),
        .stb        (stb),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .core_start (core_start),
        .core_done  (core_done),
        .core_addr  (core_addr),
        .core_we    (core_we),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One host cycle, then return the bus to IDLE.
    task automatic host(input logic [2:0] c, input logic s, input logic st, input logic [7:0] d);
        cmd = c; sel = s; stb = st; data_in = d;
        tick(1);
        cmd = C_IDLE; stb = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] p, input logic s, input logic [7:0] exp);
        host(C_SETP, 1'b0, 1'b1, {2'b00, p});
        host(C_READ, s, 1'b0, 8'h00);
        chk(tag, 16'(data_out), 16'(exp));
    endtask

    initial begin
        // Reset values
        tick(2);
        chk("rst_data_out", 16'(data_out), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_full", 16'(full), 16'h0);
        chk("rst_core_start", 16'(core_start), 16'h0);
        rst_n = 1'b1;
        tick(1);

        // Real-only sine load, 64 strobes
        cmd = C_LREAL; sel = 1'b0;
        for (int i = 0; i < 64; i++) begin
            data_in = sine_tab[i % 16];
            stb = 1'b1;
            tick(1);
            if (i == 62) chk("full_before_wrap", 16'(full), 16'h0);
        end
        stb = 1'b0; cmd = C_IDLE;
        chk("full_after_64", 16'(full), 16'h1);
        host(C_READ, 1'b1, 1'b1, 8'h00);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("ptr0_after_load", 16'(data_out), 16'd19);
        chk("full_kept_by_read", 16'(full), 16'h1);
        read_check("sine_re3", 6'd3, 1'b0, 8'd50);
        read_check("sine_im3", 6'd3, 1'b1, 8'h00);
        read_check("sine_re12", 6'd12, 1'b0, 8'hCE);

        // Interleaved load at pointer 5
        host(C_SETP, 1'b0, 1'b1, 8'd5);
        chk("setptr_clears_full", 16'(full), 16'h0);
        host(C_LOAD, 1'b0, 1'b1, 8'h12);
        host(C_LOAD, 1'b1, 1'b1, 8'hEE);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("ptr6_after_load", 16'(data_out), 16'h0026);
        host(C_SETP, 1'b0, 1'b1, 8'd5);
        cmd = C_READ; sel = 1'b0;
        tick(1);
        chk("il_read_re5", 16'(data_out), 16'h0012);
        sel = 1'b1;
        tick(1);
        chk("il_read_im5", 16'(data_out), 16'h00EE);
        cmd = C_IDLE; sel = 1'b0;
        core_addr = 6'd10;
        #1;
        chk("core_rdata10_pre", core_rdata, 16'h00DA);

        // EXEC handshake with core writes and ignored host strobes
        cmd = C_EXEC;
        tick(1);
        chk("exec_core_start", 16'(core_start), 16'h1);
        chk("exec_busy", 16'(busy), 16'h1);
        core_done = 1'b1; cmd = C_READ; sel = 1'b0;
        core_addr = 6'd4; core_we = 1'b1; core_wdata = 16'h7F80;
        tick(1);
        core_done = 1'b0;
        chk("start_pulse_one_cycle", 16'(core_start), 16'h0);
        chk("done_ignored_at_start", 16'(busy), 16'h1);
        chk("data_out_held_busy", 16'(data_out), 16'h00EE);
        core_addr = 6'd0; core_wdata = 16'h3344;
        cmd = C_SETP; stb = 1'b1; data_in = 8'd10;
        tick(1);
        core_we = 1'b0;
        cmd = C_LOAD; sel = 1'b0; data_in = 8'h55;
        tick(1);
        sel = 1'b1; data_in = 8'h66;
        tick(1);
        cmd = C_IDLE; stb = 1'b0; sel = 1'b0;
        core_addr = 6'd10;
        #1;
        chk("buf10_unchanged", core_rdata, 16'h00DA);
        core_addr = 6'd0;
        #1;
        chk("buf0_core_write", core_rdata, 16'h3344);
        tick(15);
        chk("busy_before_done", 16'(busy), 16'h1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        chk("exec_busy_fall", 16'(busy), 16'h0);
        chk("exec_done_set", 16'(done), 16'h1);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("exec_ptr_zeroed", 16'(data_out), 16'h0044);
        chk("done_kept_by_read", 16'(done), 16'h1);
        read_check("core_re4", 6'd4, 1'b0, 8'h80);
        read_check("core_im4", 6'd4, 1'b1, 8'h7F);
        chk("setptr_clears_done", 16'(done), 16'h0);

        // No retrigger while EXEC is held; minimum-length run
        cmd = C_EXEC;
        tick(1);
        chk("exec2_start", 16'(core_start), 16'h1);
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 0;
        chk("min_exec_busy", 16'(busy), 16'h0);
        chk("min_exec_done", 16'(done), 16'h1);
        starts = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            starts += int'(core_start);
        end
        chk("no_retrigger", 16'(starts), 16'h0);
        chk("no_retrigger_busy", 16'(busy), 16'h0);
        cmd = C_IDLE;
        tick(1);
        cmd = C_EXEC;
        tick(1);
        chk("exec3_start", 16'(core_start), 16'h1);
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0; cmd = C_IDLE;
        chk("exec3_busy_fall", 16'(busy), 16'h0);

        // ena=0 blocks EXEC
        ena = 1'b0; cmd = C_EXEC;
        tick(1);
        chk("ena0_no_start", 16'(core_start), 16'h0);
        chk("ena0_no_busy", 16'(busy), 16'h0);
        cmd = C_IDLE; ena = 1'b1;
        tick(1);

        // Wrap by READ and by LOAD_REAL
        host(C_SETP, 1'b0, 1'b1, 8'd63);
        host(C_READ, 1'b1, 1'b1, 8'h00);
        chk("read_wrap_full0", 16'(full), 16'h0);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("read_wrap_ptr0", 16'(data_out), 16'h0044);
        host(C_SETP, 1'b0, 1'b1, 8'd63);
        host(C_LREAL, 1'b0, 1'b1, 8'h5A);
        chk("lreal_wrap_full1", 16'(full), 16'h1);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("lreal_wrap_ptr0", 16'(data_out), 16'h0044);
        read_check("lreal_re63", 6'd63, 1'b0, 8'h5A);
        read_check("lreal_im63", 6'd63, 1'b1, 8'h00);

        // Asynchronous reset in the middle of EXEC
        cmd = C_EXEC;
        tick(1);
        chk("rexec_busy", 16'(busy), 16'h1);
        #2;
        rst_n = 1'b0;
        cmd = C_IDLE;
        #1;
        chk("async_rst_busy", 16'(busy), 16'h0);
        chk("async_rst_start", 16'(core_start), 16'h0);
        chk("async_rst_done", 16'(done), 16'h0);
        chk("async_rst_data_out", 16'(data_out), 16'h0000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        chk("late_done_busy", 16'(busy), 16'h0);
        chk("late_done_ignored", 16'(done), 16'h0);
        host(C_READ, 1'b0, 1'b0, 8'h00);
        chk("rst_ptr0", 16'(data_out), 16'h0044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
